// File: rtl/dut_if_pkg.sv
// Shared definitions for the dut write/read method interface: default widths,
// initiator state encoding and the dut register map.
package dut_if_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [2:0] ADDR_STATUS0 = 3'd0;
  localparam logic [2:0] ADDR_STATUS1 = 3'd1;
  localparam logic [2:0] ADDR_STATUS2 = 3'd2;
  localparam logic [2:0] ADDR_STATUS3 = 3'd3;
  localparam logic [2:0] ADDR_A_DATA  = 3'd4;
  localparam logic [2:0] ADDR_B_DATA  = 3'd5;

endpackage

// File: rtl/dut_bus_initiator.sv
// Single-outstanding command initiator driving the dut write_*/read_* methods.
// Optional ISSUE-phase rdy timeout enabled by macro DUT_BUS_INITIATOR_TIMEOUT_EN.
module dut_bus_initiator
  import dut_if_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef DUT_BUS_INITIATOR_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_rdy
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                w_cmd_ready;
  logic                w_write_en;
  logic                w_read_en;
  logic                w_handshake;
  logic                w_accept;
  logic                w_timeout;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;

`ifdef DUT_BUS_INITIATOR_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_rsp_err;

  // Expires on the TIMEOUT-th ISSUE cycle that sees no handshake.
  assign w_timeout = (r_state == ST_ISSUE) && (r_wait_cnt == 8'(TIMEOUT - 1));

  // Wait counter: restarts on every accepted command, saturates at 8'hFF.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wait_cnt <= 8'd0;
    end else if (w_accept) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == ST_ISSUE) && !w_handshake && (r_wait_cnt != 8'hFF)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Error flag captured alongside the response payload.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rsp_err <= 1'b0;
    end else if ((r_state == ST_ISSUE) && w_handshake) begin
      r_rsp_err <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and bus enables; enables only ever follow the matching rdy.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_write_en  = 1'b0;
    w_read_en   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_write_en  = r_is_write & write_rdy;
        w_read_en   = ~r_is_write & read_rdy;
        w_handshake = w_write_en | w_read_en;
        if (w_handshake || w_timeout) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch and response payload.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_is_write <= cmd_write;
        r_addr     <= cmd_addr;
        r_wdata    <= cmd_wdata;
      end
      if ((r_state == ST_ISSUE) && w_handshake) begin
        r_rsp_data <= r_is_write ? '0 : read_data;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
      end
    end
  end

  assign cmd_ready     = w_cmd_ready;
  assign rsp_valid     = (r_state == ST_RESP);
  assign rsp_data      = r_rsp_data;
  assign write_address = r_addr;
  assign read_address  = r_addr;
  assign write_data    = r_wdata;
  assign write_en      = w_write_en;
  assign read_en       = w_read_en;

endmodule

// File: doc/dut_bus_initiator.md
Name: dut_bus_initiator

Overview:
- Bus-side initiator for the dut write/read method interface: takes one command at a time from a valid/ready command port, drives write_* or read_* toward the dut, and returns one response per command.
- Sits in the test wrapper and system top in front of the dut, replacing direct testbench pin driving.
- Obeys method rules: enable asserted only while the matching rdy is high; read_data sampled in the read_en cycle.

Parameters:
- ADDR_W, 3, width of write_address/read_address and cmd_addr
- DATA_W, 1, width of write_data/read_data, cmd_wdata, rsp_data
- TIMEOUT, 16, cycles waited in ISSUE for rdy before an error response (used only with macro); range 1..255

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when valid&ready
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_W  target address
- cmd_wdata  input  DATA_W  write data (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when valid&ready
- rsp_data  output  DATA_W  captured read data; 0 for writes
- rsp_err  output  1  1=timed out (tied 0 without macro)
- write_address  output  ADDR_W  to dut
- write_data  output  DATA_W  to dut
- write_en  output  1  to dut
- write_rdy  input  1  from dut
- read_address  output  ADDR_W  to dut
- read_en  output  1  to dut
- read_data  input  DATA_W  from dut
- read_rdy  input  1  from dut

Behaviour:
- Reset (async, RST_N=0): state=IDLE; cmd_ready=1 after reset release; rsp_valid=0, rsp_data=0, rsp_err=0, write_en=0, read_en=0, write_address/read_address/write_data=0; command registers cleared.
- States: IDLE, ISSUE, RESP.
- IDLE: cmd_ready=1. On cmd_valid: latch write/addr/wdata, go ISSUE next cycle.
- ISSUE: cmd_ready=0. Address/data outputs driven from latched registers (both address buses carry the latched address). write_en = is_write & write_rdy; read_en = ~is_write & read_rdy (combinational from registered state and rdy, never high when rdy is low). On the handshake cycle: reads capture read_data into rsp_data, writes load rsp_data=0; rsp_err=0; go RESP.
- RESP: rsp_valid=1, outputs held stable until rsp_ready; then IDLE. No new command is accepted in RESP; max one command outstanding.
- Latency: command accepted cycle N -> earliest bus enable N+1 -> rsp_valid N+2. Back-to-back throughput with rdy and rsp_ready held high is one command per 3 cycles.
- Exactly one enable pulse per command; enable lasts exactly one cycle.
- rdy dropping before the handshake only delays; no partial transfer.
- Reset mid-ISSUE or mid-RESP: command and pending response discarded, enables drop immediately (async).

Optional Feature:
- Macro: DUT_BUS_INITIATOR_TIMEOUT_EN.
- With macro: 8-bit wait counter cleared on IDLE->ISSUE and incremented each ISSUE cycle without a handshake. When the counter reaches TIMEOUT with no handshake, go RESP with rsp_err=1, rsp_data=0, no enable issued.
- Without macro: no counter; ISSUE waits indefinitely; rsp_err constant 0.

Decomposition:
- Shared package dut_if_pkg: ADDR_W/DATA_W defaults, state enum (IDLE/ISSUE/RESP), dut address constants (status addresses 0-3, A data 4, B data 5).
- Single module, no sub-module. The timeout counter is inline under the macro.

Test Plan:
- Write addr 4 data 1, write_rdy=1, rsp_ready=1 -> write_en high exactly cycle N+1 with write_address=4, write_data=1; rsp_valid at N+2, rsp_data=0, rsp_err=0.
- Read addr 3, read_rdy low 5 cycles then high, read_data=1 -> read_en only in the first read_rdy-high cycle; rsp_data=1 one cycle later.
- rsp_ready low for 4 cycles after response -> rsp_valid/rsp_data stable, cmd_ready=0, no enables; on release, cmd_ready=1 the cycle after.
- RST_N pulsed low while in ISSUE with write_rdy low -> all outputs reset immediately; after release, write_rdy=1 produces no write_en until a new command.
- Macro on, TIMEOUT=4, read addr 5 with read_rdy=0 -> read_en never asserted; rsp_valid with rsp_err=1, rsp_data=0 after 4 ISSUE cycles.
- Three back-to-back commands (write 4/1, write 5/0, read 2) with all rdy high -> enables at cycles 1, 4, 7; responses in order.
